// File: rtl/sw_debounce.sv
// Per-bit synchroniser + debouncer for the switch bank: clean levels plus one-cycle rise/fall pulses, all registered.
// Optional SW_INIT_SAMPLE_EN: load sw_clean straight from the synchroniser once it is filled after reset, with no pulses.
module sw_debounce #(
   parameter int WIDTH         = 8,
   parameter int STABLE_CYCLES = 1000000,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
);

   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] commit;
   logic [CW-1:0]    cnt [WIDTH];

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= sw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   // A bit commits on the STABLE_CYCLES-th consecutive cycle of disagreement.
   always_comb begin
      commit = '0;
      for (int i = 0; i < WIDTH; i++)
         commit[i] = (s[i] != sw_clean[i]) && (cnt[i] == LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if ((s[i] == sw_clean[i]) || commit[i])
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + CW'(1);
         end
      end
   end

`ifdef SW_INIT_SAMPLE_EN
   localparam int IW = $clog2(SYNC_STAGES + 1);
   logic [IW-1:0] init_cnt;
   logic          init_load;

   // Fires on the edge that loads the last synchroniser stage for the first time.
   assign init_load = (init_cnt == IW'(SYNC_STAGES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         init_cnt <= '0;
      else if (init_cnt != IW'(SYNC_STAGES))
         init_cnt <= init_cnt + IW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_clean <= '0;
         sw_rise  <= '0;
         sw_fall  <= '0;
      end else if (init_load) begin
         sw_clean <= sync_q[SYNC_STAGES-2];
         sw_rise  <= '0;
         sw_fall  <= '0;
      end else begin
         sw_clean <= (sw_clean & ~commit) | (s & commit);
         sw_rise  <= commit & s;
         sw_fall  <= commit & ~s;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_clean <= '0;
         sw_rise  <= '0;
         sw_fall  <= '0;
      end else begin
         sw_clean <= (sw_clean & ~commit) | (s & commit);
         sw_rise  <= commit & s;
         sw_fall  <= commit & ~s;
      end
   end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_sw_debounce;

   logic       clk;
   logic       rst;
   logic [7:0] sw;
   logic [7:0] sw_clean;
   logic [7:0] sw_rise;
   logic [7:0] sw_fall;

   int npass  = 0;
   int ntotal = 0;

   typedef struct {
      logic       rst;
      logic [7:0] sw;
      logic [7:0] clean;
      logic [7:0] rise;
      logic [7:0] fall;
   } vec_t;

   vec_t vecs[$];

   sw_debounce #(.WIDTH(8), .STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .sw_clean (sw_clean),
      .sw_rise  (sw_rise),
      .sw_fall  (sw_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic add(input logic r, input logic [7:0] s, input logic [7:0] c,
                      input logic [7:0] ri, input logic [7:0] fa, input int n);
      vec_t v;
      v.rst = r; v.sw = s; v.clean = c; v.rise = ri; v.fall = fa;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic check_all(input string tag, input logic [7:0] c,
                            input logic [7:0] ri, input logic [7:0] fa);
      check({tag, " clean"}, sw_clean, c);
      check({tag, " rise"},  sw_rise,  ri);
      check({tag, " fall"},  sw_fall,  fa);
   endtask

   initial begin
      rst = 1'b0;
      sw  = 8'hFF;
      #1 rst = 1'b1;
      #1 check_all("async_reset", 8'h00, 8'h00, 8'h00);

`ifdef SW_INIT_SAMPLE_EN
      sw = 8'hA3;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check_all("init_edge1", 8'h00, 8'h00, 8'h00);
      @(posedge clk); #1;
      check_all("init_edge2", 8'hA3, 8'h00, 8'h00);
      for (int i = 3; i <= 10; i++) begin
         @(posedge clk); #1;
         check_all($sformatf("init_hold%0d", i), 8'hA3, 8'h00, 8'h00);
      end
`else
      // reset held with switches high, then released
      add(1, 8'hFF, 8'h00, 8'h00, 8'h00, 2);
      add(0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      // clean step 00 -> 05: visible on the 6th edge
      add(0, 8'h05, 8'h00, 8'h00, 8'h00, 5);
      add(0, 8'h05, 8'h05, 8'h05, 8'h00, 1);
      add(0, 8'h05, 8'h05, 8'h00, 8'h00, 1);
      // sw[3] high 3 cycles: rejected
      add(0, 8'h0D, 8'h05, 8'h00, 8'h00, 3);
      add(0, 8'h05, 8'h05, 8'h00, 8'h00, 5);
      // sw[3] high 4 cycles: commits, then the return to 0 debounces as a fall
      add(0, 8'h0D, 8'h05, 8'h00, 8'h00, 4);
      add(0, 8'h05, 8'h05, 8'h00, 8'h00, 1);
      add(0, 8'h05, 8'h0D, 8'h08, 8'h00, 1);
      add(0, 8'h05, 8'h0D, 8'h00, 8'h00, 3);
      add(0, 8'h05, 8'h05, 8'h00, 8'h08, 1);
      add(0, 8'h05, 8'h05, 8'h00, 8'h00, 1);
      // synchronous-looking reset row then bounce on bit 0
      add(1, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      add(0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      add(0, 8'h01, 8'h00, 8'h00, 8'h00, 1);
      add(0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      add(0, 8'h01, 8'h00, 8'h00, 8'h00, 1);
      add(0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      add(0, 8'h01, 8'h00, 8'h00, 8'h00, 5);
      add(0, 8'h01, 8'h01, 8'h01, 8'h00, 1);
      add(0, 8'h01, 8'h01, 8'h00, 8'h00, 1);
      // all high, then bit 7 falls
      add(0, 8'hFF, 8'h01, 8'h00, 8'h00, 5);
      add(0, 8'hFF, 8'hFF, 8'hFE, 8'h00, 1);
      add(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1);
      add(0, 8'h7F, 8'hFF, 8'h00, 8'h00, 5);
      add(0, 8'h7F, 8'h7F, 8'h00, 8'h80, 1);
      add(0, 8'h7F, 8'h7F, 8'h00, 8'h00, 1);

      foreach (vecs[n]) begin
         rst = vecs[n].rst;
         sw  = vecs[n].sw;
         @(posedge clk); #1;
         check_all($sformatf("vec%0d", n), vecs[n].clean, vecs[n].rise, vecs[n].fall);
      end

      // reset asserted while bit 7 is settling towards 0
      sw = 8'hFF;
      repeat (7) @(posedge clk);
      #1 check("pre_fall clean", sw_clean, 8'hFF);
      sw = 8'h7F;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all("mid_count_reset", 8'h00, 8'h00, 8'h00);
      @(posedge clk); #1;
      check_all("mid_count_reset_edge", 8'h00, 8'h00, 8'h00);
      rst = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         check_all($sformatf("post_reset%0d", i),
                   (i >= 6) ? 8'h7F : 8'h00,
                   (i == 6) ? 8'h7F : 8'h00,
                   8'h00);
      end
`endif

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage between the board slide switches and the switch-driven logic (stair light, half adder, 2-bit ripple adder).
- Synchronises each raw switch bit to clk and suppresses contact bounce.
- Presents clean levels plus single-cycle rise/fall pulses, so downstream combinational and future sequential logic never sees metastable or chattering inputs.
- One instance covers the full 8-switch bank.

Parameters:
- WIDTH, 8, number of independent switch bits.
- STABLE_CYCLES, 1000000, consecutive clk cycles a synchronised bit must differ from its clean value before the clean value updates (10 ms at 100 MHz); legal range >= 1.
- SYNC_STAGES, 2, synchroniser flop depth per bit; legal range >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw  input  WIDTH  raw switch levels, asynchronous to clk.
- sw_clean  output  WIDTH  debounced switch levels.
- sw_rise  output  WIDTH  one-cycle pulse when sw_clean[i] goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse when sw_clean[i] goes 1->0.

Behaviour:
- Reset: asynchronous, active-high; one clock. While rst=1, all synchroniser flops, counters, sw_clean, sw_rise and sw_fall are 0. Reset asserted mid-count aborts the count with no pulse.
- Per bit i, fully independent: synchroniser chain of SYNC_STAGES flops; s[i] is the last stage.
- Per-bit counter cnt[i], width clog2(STABLE_CYCLES+1); states:
  - IDLE (s[i]==sw_clean[i]): cnt<=0.
  - SETTLING (s[i]!=sw_clean[i]): cnt<=cnt+1.
- Commit: in SETTLING with cnt==STABLE_CYCLES-1:
  - sw_clean[i] <= s[i] and cnt<=0.
  - sw_rise[i] or sw_fall[i] asserted for exactly that next cycle.
- Glitch: s[i] returns to sw_clean[i] before commit -> back to IDLE, cnt cleared, no output change, no pulse.
- Latency: a clean step on sw[i] reaches sw_clean[i] after exactly SYNC_STAGES+STABLE_CYCLES rising edges. The pulse is coincident with the sw_clean change.
- STABLE_CYCLES=1: commits on the first mismatched cycle.
- Simultaneous changes on several bits: each bit is handled independently; multiple pulse bits may be high in the same cycle.
- sw_rise[i] and sw_fall[i] are never high together; pulses are never longer than one cycle.
- No combinational path from sw to any output; all outputs are registered.

Optional Feature:
- Macro: SW_INIT_SAMPLE_EN.
- Defined:
  - On the first cycle after rst deasserts in which the synchroniser chain is fully loaded (SYNC_STAGES cycles after release), sw_clean is loaded directly from s with no debounce delay.
  - No rise/fall pulses are generated for this load.
  - Normal debounce applies thereafter.
  - Purpose: switches already high at power-up show correctly without spurious edge events.
- Undefined:
  - sw_clean starts at 0.
  - Switches high at reset go through the normal debounce and produce sw_rise pulses.

Test Plan:
All scenarios use WIDTH=8, STABLE_CYCLES=4, SYNC_STAGES=2, macro undefined unless stated.
- Reset state: rst=1 with sw=8'hFF -> sw_clean=8'h00, sw_rise=sw_fall=8'h00 during and immediately after reset, independent of clk.
- Clean step: sw 8'h00->8'h05 at edge 0 -> sw_clean=8'h05 and sw_rise=8'h05 at edge 6, sw_rise=8'h00 at edge 7.
- Glitch reject: sw[3] high for 3 cycles then low -> sw_clean[3] stays 0, no pulse. sw[3] high for 4 cycles -> commits, sw_rise[3] pulses once.
- Bounce: sw[0] toggles 1,0,1,0,1 on successive cycles, then held 1 -> exactly one sw_rise[0] pulse, 6 edges after the final transition.
- Fall and reset mid-count:
  - With sw_clean=8'hFF, sw->8'h7F -> one sw_fall[7] pulse, sw_clean=8'h7F.
  - Repeat with rst pulsed during SETTLING -> all outputs 0, no pulse.
- Init sample (SW_INIT_SAMPLE_EN defined): sw=8'hA3 held through reset -> sw_clean=8'hA3, 2 edges after release, sw_rise stays 8'h00.
